// File: rtl/branch_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl_pkg
// Shared definitions for the branch hazard controller: opcode constants,
// the controller state encoding and small opcode decode helpers.
// ---------------------------------------------------------------------------
package branch_hazard_ctrl_pkg;

    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_HALTED  = 2'd3
    } state_t;

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_B) || (op == OP_BR);
    endfunction

    function automatic logic is_halt(input logic [3:0] op);
        return op == OP_HLT;
    endfunction

endpackage

// File: rtl/branch_hazard_ctrl_br_hazard_detect.sv
// ---------------------------------------------------------------------------
// br_hazard_detect
// Combinational detection of control hazards for a branch sitting in ID.
//   i_id_opcode   : opcode of the ID instruction
//   i_id_rs       : source register of a BR in ID
//   i_ex_flag_wr  : EX instruction updates Z/V/N
//   i_ex_wr_en    : EX instruction writes a register
//   i_ex_rd       : EX destination register
//   i_ex_is_load  : EX instruction is a load
//   o_hazard      : branch in ID must stall this cycle
//   o_load_hazard : hazard is a BR register dependence on a load (extra stall)
// ---------------------------------------------------------------------------
module br_hazard_detect
    import branch_hazard_ctrl_pkg::*;
(
    input  logic [3:0] i_id_opcode,
    input  logic [3:0] i_id_rs,
    input  logic       i_ex_flag_wr,
    input  logic       i_ex_wr_en,
    input  logic [3:0] i_ex_rd,
    input  logic       i_ex_is_load,
    output logic       o_hazard,
    output logic       o_load_hazard
);

    logic w_flag_dep;
    logic w_reg_dep;

    // Any branch consumes the flags; only BR reads a register.
    assign w_flag_dep    = is_branch(i_id_opcode) && i_ex_flag_wr;
    assign w_reg_dep     = (i_id_opcode == OP_BR) && i_ex_wr_en && (i_ex_rd == i_id_rs);
    assign o_hazard      = w_flag_dep || w_reg_dep;
    assign o_load_hazard = w_reg_dep && i_ex_is_load;

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl
// Pipeline control for branches and halts: stalls on branch hazards (two
// cycles when a BR depends on a load), flushes IF/ID on a taken branch,
// halts on HLT, freezes everything on a memory stall, counts stall cycles.
//   clk, rst        : clock, synchronous active-high reset
//   id_opcode/id_rs : ID instruction opcode and BR source register
//   br_taken        : branch condition for the ID branch
//   ex_flag_wr, ex_wr_en, ex_rd, ex_is_load : EX instruction info
//   mem_stall       : memory miss, pipeline frozen
//   pc_we, ifid_we  : PC and IF/ID write enables
//   ifid_flush      : IF/ID loads a NOP at the next edge
//   idex_bubble     : ID/EX loads a NOP at the next edge
//   halted          : processor halted
//   stall_cnt       : saturating count of stall cycles
// ---------------------------------------------------------------------------
module branch_hazard_ctrl
    import branch_hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_opcode,
    input  logic [3:0]  id_rs,
    input  logic        br_taken,
    input  logic        ex_flag_wr,
    input  logic        ex_wr_en,
    input  logic [3:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        mem_stall,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_wait_cnt;
    logic        w_wait_nxt;
    logic [15:0] r_stall_cnt;
    logic        w_hazard;
    logic        w_load_hazard;

    br_hazard_detect u_detect (
        .i_id_opcode   (id_opcode),
        .i_id_rs       (id_rs),
        .i_ex_flag_wr  (ex_flag_wr),
        .i_ex_wr_en    (ex_wr_en),
        .i_ex_rd       (ex_rd),
        .i_ex_is_load  (ex_is_load),
        .o_hazard      (w_hazard),
        .o_load_hazard (w_load_hazard)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (rst) begin
            // Reset forces normal-flow enables regardless of state or mem_stall.
        end else if (mem_stall) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (is_halt(id_opcode)) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        w_state_nxt = ST_HALTED;
                    end else if (w_hazard) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                        if (w_load_hazard) begin
                            w_state_nxt = ST_BR_WAIT;
                            w_wait_nxt  = 1'b1;
                        end
                    end else if (is_branch(id_opcode) && br_taken) begin
                        ifid_flush  = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end
                end
                ST_BR_WAIT: begin
                    // ID still holds the stalled BR; its fields are not re-examined here.
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                    w_wait_nxt  = r_wait_cnt - 1'b1;
                    if (w_wait_nxt == 1'b0) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    w_state_nxt = ST_RUN;
                end
                ST_HALTED: begin
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    assign halted    = (r_state == ST_HALTED) && !rst;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= 1'b0;
            r_stall_cnt <= '0;
        end else if (!mem_stall) begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (!pc_we && !halted && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
module tb_branch_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  id_opcode;
    logic [3:0]  id_rs;
    logic        br_taken;
    logic        ex_flag_wr;
    logic        ex_wr_en;
    logic [3:0]  ex_rd;
    logic        ex_is_load;
    logic        mem_stall;
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        halted;
    logic [15:0] stall_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: pending extra stall cycles, flush slot, halt, stall count.
    bit m_known  = 1'b0;
    bit m_halted = 1'b0;
    bit m_flush  = 1'b0;
    int m_wait   = 0;
    int m_cnt    = 0;

    always #5 clk = ~clk;

    branch_hazard_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_opcode   (id_opcode),
        .id_rs       (id_rs),
        .br_taken    (br_taken),
        .ex_flag_wr  (ex_flag_wr),
        .ex_wr_en    (ex_wr_en),
        .ex_rd       (ex_rd),
        .ex_is_load  (ex_is_load),
        .mem_stall   (mem_stall),
        .pc_we       (pc_we),
        .ifid_we     (ifid_we),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .halted      (halted),
        .stall_cnt   (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] rs, input logic tk,
                         input logic fw, input logic we, input logic [3:0] rd,
                         input logic ld, input logic ms, input logic r);
        id_opcode  = op;
        id_rs      = rs;
        br_taken   = tk;
        ex_flag_wr = fw;
        ex_wr_en   = we;
        ex_rd      = rd;
        ex_is_load = ld;
        mem_stall  = ms;
        rst        = r;
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        bit br, haz, ldh, hlt, eh;
        bit [3:0] e;
        @(negedge clk);
        br  = (id_opcode == 4'hC) || (id_opcode == 4'hD);
        haz = (br && ex_flag_wr) || (id_opcode == 4'hD && ex_wr_en && ex_rd == id_rs);
        ldh = (id_opcode == 4'hD) && ex_wr_en && (ex_rd == id_rs) && ex_is_load;
        hlt = (id_opcode == 4'hF);
        eh  = 1'b0;
        if (rst)                    e = 4'b1100;
        else if (mem_stall) begin   e = 4'b0000; eh = m_halted; end
        else if (m_halted) begin    e = 4'b0000; eh = 1'b1; end
        else if (m_wait > 0)        e = 4'b0001;
        else if (m_flush)           e = 4'b1100;
        else if (hlt)               e = 4'b0000;
        else if (haz)               e = 4'b0001;
        else if (br && br_taken)    e = 4'b1110;
        else                        e = 4'b1100;
        chk("pc_we",       {31'd0, pc_we},       {31'd0, e[3]});
        chk("ifid_we",     {31'd0, ifid_we},     {31'd0, e[2]});
        chk("ifid_flush",  {31'd0, ifid_flush},  {31'd0, e[1]});
        chk("idex_bubble", {31'd0, idex_bubble}, {31'd0, e[0]});
        chk("halted",      {31'd0, halted},      {31'd0, eh});
        if (m_known) chk("stall_cnt", {16'd0, stall_cnt}, m_cnt);
        @(posedge clk);
        if (rst) begin
            m_known = 1'b1; m_halted = 1'b0; m_flush = 1'b0; m_wait = 0; m_cnt = 0;
        end else if (!mem_stall) begin
            if (!e[3] && !eh && m_cnt < 65535) m_cnt++;
            if (m_halted)            ;
            else if (m_wait > 0)     m_wait--;
            else if (m_flush)        m_flush = 1'b0;
            else if (hlt)            m_halted = 1'b1;
            else if (haz)            m_wait = ldh ? 1 : 0;
            else if (br && br_taken) m_flush = 1'b1;
        end
        #1;
    endtask

    task automatic nop(input int n);
        drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        cycle();
        rst = 1'b0;
    endtask

    logic [15:0] saved;

    initial begin
        drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        #1;
        cycle();
        cycle();
        nop(2);
        chk("reset_cnt", {16'd0, stall_cnt}, 32'd0);

        // Flag hazard on a taken B: one stall, then flush, then FLUSH slot.
        do_reset();
        drive(4'hC, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0); cycle();
        drive(4'hC, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0); cycle();
        drive(4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0); cycle();
        nop(1);
        chk("b_flag_cnt", {16'd0, stall_cnt}, 32'd1);

        // BR on a load result: two stalls, then taken BR flushes.
        do_reset();
        drive(4'hD, 4'h5, 1'b0, 1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0); cycle();
        drive(4'hD, 4'h5, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0); cycle();
        chk("br_load_cnt", {16'd0, stall_cnt}, 32'd2);
        drive(4'hD, 4'h5, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0); cycle();
        nop(2);

        // mem_stall freezes BR_WAIT for three cycles.
        do_reset();
        drive(4'hD, 4'h5, 1'b0, 1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0); cycle();
        drive(4'hD, 4'h5, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0); repeat (3) cycle();
        chk("freeze_cnt", {16'd0, stall_cnt}, 32'd1);
        mem_stall = 1'b0; cycle();
        chk("resume_cnt", {16'd0, stall_cnt}, 32'd2);
        nop(2);

        // HLT: halted for 10 cycles with stall_cnt unchanged, then reset.
        do_reset();
        drive(4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0); cycle();
        saved = stall_cnt;
        drive(4'hC, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0); repeat (10) cycle();
        chk("halt_cnt_hold", {16'd0, stall_cnt}, {16'd0, saved});
        chk("halt_flag", {31'd0, halted}, 32'd1);
        do_reset();
        nop(2);

        // Reset mid-FLUSH with mem_stall high.
        do_reset();
        drive(4'hC, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0); cycle();
        drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1); cycle();
        nop(1);
        chk("rst_flush_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst_flush_pc", {31'd0, pc_we}, 32'd1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] op;
            case ($urandom_range(0, 9))
                0, 1, 2: op = 4'hC;
                3, 4, 5: op = 4'hD;
                6:       op = ($urandom_range(0, 3) == 0) ? 4'hF : 4'h1;
                default: op = 4'($urandom_range(0, 11));
            endcase
            drive(op, 4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                  1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom),
                  1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 40) == 0));
            cycle();
        end

        // Saturation: hold a flag hazard until the counter reaches its ceiling.
        do_reset();
        drive(4'hC, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        repeat (65534) cycle();
        chk("preload_cnt", {16'd0, stall_cnt}, 32'h0000FFFE);
        repeat (3) cycle();
        chk("sat_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_hazard_ctrl.md
BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 id_opcode  in  4  opcode of instruction in ID.
REQ-004 id_rs  in  4  source register of BR instruction in ID.
REQ-005 br_taken  in  1  branch condition true for ID instruction; valid only when ID opcode is B (4'hC) or BR (4'hD).
REQ-006 ex_flag_wr  in  1  EX instruction writes flags Z/V/N.
REQ-007 ex_wr_en, ex_rd, ex_is_load  in  1/4/1  EX instruction register write, destination, load indicator.
REQ-008 mem_stall  in  1  memory miss; pipeline frozen while high.
REQ-009 pc_we  out  1  PC register write enable.
REQ-010 ifid_we  out  1  IF/ID register write enable.
REQ-011 ifid_flush  out  1  IF/ID loads NOP (invalid) at next edge.
REQ-012 idex_bubble  out  1  ID/EX loads NOP at next edge.
REQ-013 halted  out  1  processor halted.
REQ-014 stall_cnt  out  16  count of stall cycles.

Function
REQ-015 The FSM SHALL have states RUN, BR_WAIT, FLUSH and HALTED; outputs are combinational from state and current inputs.
REQ-016 Branch instruction: id_opcode is 4'hC (B) or 4'hD (BR); halt instruction: id_opcode 4'hF.
REQ-017 Hazard: branch in ID with ex_flag_wr=1, or BR in ID with ex_wr_en=1 and ex_rd==id_rs.
REQ-018 Priority per cycle: rst > mem_stall > HALTED > halt in ID > hazard > taken branch > normal.
REQ-019 mem_stall=1: pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=0; state, wait counter and stall_cnt hold; this applies in every state.
REQ-020 RUN, no event: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0.
REQ-021 RUN, halt in ID: pc_we=0, ifid_we=0, idex_bubble=0; next state HALTED.
REQ-022 RUN, hazard: pc_we=0, ifid_we=0, idex_bubble=1 in that cycle.
REQ-023 On a hazard from a BR register dependence with ex_is_load=1, the next state SHALL be BR_WAIT with a 1-bit wait counter of 1; any other hazard remains in RUN, giving 1 stall cycle.
REQ-024 BR_WAIT: same outputs as REQ-022; counter decrements; at 0 return to RUN; br_taken is ignored. The load case totals 2 stall cycles.
REQ-025 RUN, no hazard, branch with br_taken=1: pc_we=1, ifid_we=1, ifid_flush=1; next state FLUSH.
REQ-026 FLUSH lasts 1 cycle with REQ-020 outputs; br_taken and hazard checks are suppressed because ID holds a NOP; it then returns to RUN. A halt opcode here is treated as a NOP.
REQ-027 HALTED: pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=0, halted=1 until rst.
REQ-028 stall_cnt increments each cycle with pc_we=0, halted=0 and mem_stall=0; it saturates at 16'hFFFF and does not wrap.
REQ-029 A not-taken branch with no hazard SHALL behave as REQ-020.

Reset
REQ-030 rst=1 at an edge: state RUN, wait counter 0, stall_cnt 0, regardless of current state, including mid-BR_WAIT or HALTED.
REQ-031 During and after reset: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0, halted=0; rst overrides mem_stall.

Structure
REQ-032 A shared package SHALL hold opcode constants B=4'hC, BR=4'hD, HLT=4'hF and the 2-bit state encoding RUN=0, BR_WAIT=1, FLUSH=2, HALTED=3.
REQ-033 Sub-module br_hazard_detect (combinational) SHALL produce the hazard and load_hazard signals from the ID/EX fields; the FSM, wait counter and stall counter stay in branch_hazard_ctrl.

Verification
REQ-034 B opcode (4'hC) in ID, ex_flag_wr=1, br_taken=1 -> 1 cycle with pc_we=0 and idex_bubble=1, next cycle ifid_flush=1, then FLUSH for 1 cycle; stall_cnt=1.
REQ-035 BR opcode (4'hD) with id_rs=5, EX load with ex_rd=5 -> 2 stall cycles (state BR_WAIT on the 2nd); stall_cnt=2; then br_taken=1 gives ifid_flush=1.
REQ-036 BR_WAIT with mem_stall=1 for 3 cycles -> all enables 0, counter and stall_cnt frozen; resumes with 1 stall cycle remaining.
REQ-037 HLT opcode (4'hF) in ID -> halted=1 next cycle, pc_we=0 held 10 cycles; stall_cnt unchanged; rst=1 -> RUN with pc_we=1.
REQ-038 Preload stall_cnt to 16'hFFFE, hold a hazard for 3 cycles -> value 16'hFFFF, no wrap.
REQ-039 rst asserted mid-FLUSH with mem_stall=1 -> next cycle RUN, stall_cnt=0, pc_we=1.
